// File: rtl/mem_wb_reg_pkg.sv
// Shared pipeline definitions for the MEM/WB boundary: writeback select encodings,
// the hard-wired zero register, and the WB entry layouts.
package mem_wb_reg_pkg;

  localparam logic [1:0] WB_SEL_DMEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  // Raw fields captured from the MEM stage; wdata is resolved after the register.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [1:0]  sel;
    logic [31:0] alu_result;
    logic [31:0] dmem_rdata;
    logic [31:0] pc;
  } wb_reg_t;

  // Resolved writeback entry, as seen by the register file and forwarding.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;

  function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                            input logic [31:0] alu_result,
                                            input logic [31:0] dmem_rdata,
                                            input logic [31:0] pc,
                                            input logic [31:0] link_offset);
    logic [31:0] data;
    case (sel)
      WB_SEL_DMEM: data = dmem_rdata;
      WB_SEL_LINK: data = pc + link_offset;
      default:     data = alu_result;
    endcase
    return data;
  endfunction

  // An entry only really writes when it is valid, enabled and not aimed at $0.
  function automatic logic eff_we(input wb_entry_t e);
    return e.valid & e.we & (e.waddr != GPR_ZERO);
  endfunction

endpackage

// File: rtl/mem_wb_reg_fwd_match.sv
// Forwarding lookup for one ID-stage source operand against the WB entry and
// the one-deep history entry; the WB entry is the younger and wins.
module wb_fwd_match
  import mem_wb_reg_pkg::*;
(
  input  logic [4:0]  i_query_addr,
  input  wb_entry_t   i_wb,
  input  wb_entry_t   i_hist,
  output logic        o_hit,
  output logic [31:0] o_data
);

  logic w_query_live;
  logic w_wb_match;
  logic w_hist_match;

  assign w_query_live = (i_query_addr != GPR_ZERO);
  assign w_wb_match   = w_query_live & eff_we(i_wb) & (i_wb.waddr == i_query_addr);
  assign w_hist_match = w_query_live & eff_we(i_hist) & (i_hist.waddr == i_query_addr);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    if (w_wb_match) begin
      o_hit  = 1'b1;
      o_data = i_wb.wdata;
    end else if (w_hist_match) begin
      o_hit  = 1'b1;
      o_data = i_hist.wdata;
    end
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: holds the writeback entry, a one-deep history of the
// previous entry for late forwarding, and the retired-instruction counter.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter logic [31:0] PC_LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_GPR_we,
  input  logic [4:0]  mem_GPR_waddr,
  input  logic [1:0]  mem_GPR_wdata_select,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_dmem_rdata,
  input  logic [31:0] mem_pc,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  output logic        wb_GPR_we,
  output logic [4:0]  wb_GPR_waddr,
  output logic [31:0] wb_GPR_wdata,
  output logic        fwd_rs_hit,
  output logic        fwd_rt_hit,
  output logic [31:0] fwd_rs_data,
  output logic [31:0] fwd_rt_data,
  output logic [31:0] instret
);

  wb_reg_t     r_wb;
  wb_entry_t   r_hist;
  logic [31:0] r_instret;

  wb_reg_t     w_wb_next;
  wb_entry_t   w_wb_entry;

  always_comb begin
    w_wb_next            = '0;
    w_wb_next.valid      = mem_valid;
    w_wb_next.we         = mem_GPR_we;
    w_wb_next.waddr      = mem_GPR_waddr;
    w_wb_next.sel        = mem_GPR_wdata_select;
    w_wb_next.alu_result = mem_alu_result;
    w_wb_next.dmem_rdata = mem_dmem_rdata;
    w_wb_next.pc         = mem_pc;
  end

  // Writeback data is resolved after the register so it is ready the same cycle.
  always_comb begin
    w_wb_entry       = '0;
    w_wb_entry.valid = r_wb.valid;
    w_wb_entry.we    = r_wb.we;
    w_wb_entry.waddr = r_wb.waddr;
    w_wb_entry.wdata = wb_select(r_wb.sel, r_wb.alu_result, r_wb.dmem_rdata, r_wb.pc,
                                 PC_LINK_OFFSET);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb      <= '0;
      r_hist    <= '0;
      r_instret <= '0;
    end else if (ena) begin
      r_hist <= w_wb_entry;
      if (flush) begin
        r_wb <= '0;
      end else begin
        r_wb <= w_wb_next;
        if (mem_valid) begin
          r_instret <= r_instret + 32'd1;
        end
      end
    end
  end

  assign wb_GPR_we    = eff_we(w_wb_entry);
  assign wb_GPR_waddr = r_wb.waddr;
  assign wb_GPR_wdata = w_wb_entry.wdata;
  assign instret      = r_instret;

  wb_fwd_match u_fwd_rs (
    .i_query_addr (id_rs_addr),
    .i_wb         (w_wb_entry),
    .i_hist       (r_hist),
    .o_hit        (fwd_rs_hit),
    .o_data       (fwd_rs_data)
  );

  wb_fwd_match u_fwd_rt (
    .i_query_addr (id_rt_addr),
    .i_wb         (w_wb_entry),
    .i_hist       (r_hist),
    .o_hit        (fwd_rt_hit),
    .o_data       (fwd_rt_data)
  );

endmodule
